// File: rtl/memoryaccess_stage.sv
// rtl/memoryaccess_stage.sv - pipeline memory-access stage with data-memory req/ack port
//
// Holds one instruction between the ALU stage and writeback. Memory ops issue a
// single req/ack transaction; load data is lane-extracted and sign/zero-extended.
//
// Ports:
//   h_clk, h_rst               clock, asynchronous active-low reset
//   h_i_*  (ALU side)          incoming instruction, stall from WB, flush
//   h_o_stall                  stall to the ALU stage
//   h_o_fwd_*                  stage result for the forwarding unit
//   h_o_misaligned             stage instruction is a misaligned access
//   h_o_dmem_*, h_i_dmem_*     data-memory request/acknowledge port
//   h_o_wb_*                   registered writeback bus
module memoryaccess_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              h_clk,
    input  logic              h_rst,
    input  logic              h_i_ce,
    input  logic              h_i_we_reg,
    input  logic [AWIDTH-1:0] h_i_addr_rd,
    input  logic [DWIDTH-1:0] h_i_alu_result,
    input  logic [DWIDTH-1:0] h_i_rs2_data,
    input  logic              h_i_is_load,
    input  logic              h_i_is_store,
    input  logic [2:0]        h_i_funct3,
    input  logic              h_i_stall,
    input  logic              h_i_flush,
    output logic              h_o_stall,
    output logic              h_o_fwd_ce,
    output logic              h_o_fwd_we_reg,
    output logic [AWIDTH-1:0] h_o_fwd_addr_rd,
    output logic [DWIDTH-1:0] h_o_fwd_data_rd,
    output logic              h_o_fwd_valid,
    output logic              h_o_misaligned,
    output logic              h_o_dmem_req,
    output logic              h_o_dmem_we,
    output logic [DWIDTH-1:0] h_o_dmem_addr,
    output logic [DWIDTH-1:0] h_o_dmem_wdata,
    output logic [3:0]        h_o_dmem_be,
    input  logic              h_i_dmem_ack,
    input  logic [DWIDTH-1:0] h_i_dmem_rdata,
    output logic              h_o_wb_ce,
    output logic              h_o_wb_we_reg,
    output logic [AWIDTH-1:0] h_o_wb_addr_rd,
    output logic [DWIDTH-1:0] h_o_wb_data_rd
);

    typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                s_valid_q, s_valid_d;
    logic                s_complete_q, s_complete_d;
    logic                s_we_reg_q, s_we_reg_d;
    logic [AWIDTH-1:0]   s_rd_q, s_rd_d;
    logic [DWIDTH-1:0]   s_data_q, s_data_d;
    logic [DWIDTH-1:0]   s_addr_q, s_addr_d;
    logic [DWIDTH-1:0]   s_wdata_q, s_wdata_d;
    logic [2:0]          s_funct3_q, s_funct3_d;
    logic                s_load_q, s_load_d;
    logic                s_store_q, s_store_d;
    logic                s_misal_q, s_misal_d;

    logic                wb_ce_q;
    logic                wb_we_reg_q;
    logic [AWIDTH-1:0]   wb_rd_q;
    logic [DWIDTH-1:0]   wb_data_q;

    logic                accept;
    logic                retire;
    logic                wb_load;
    logic                in_mem;
    logic                in_misal;
    logic [1:0]          off;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [DWIDTH-1:0]   ld_data;
    logic [DWIDTH-1:0]   st_wdata;
    logic [3:0]          st_be;

    assign h_o_stall = s_valid_q && !(s_complete_q && !h_i_stall);
    assign accept    = h_i_ce && !h_o_stall && !h_i_flush;
    assign retire    = s_valid_q && s_complete_q && !h_i_stall;
    // A flush outside ST_REQ kills the stage instruction, so it never reaches WB.
    assign wb_load   = retire && !h_i_flush;

    assign in_mem   = h_i_is_load || h_i_is_store;
    assign in_misal = in_mem &&
                      ((h_i_funct3[1:0] == 2'b01 && h_i_alu_result[0]) ||
                       (h_i_funct3[1:0] == 2'b10 && h_i_alu_result[1:0] != 2'b00));

    // Load lane extraction from the stage address offset.
    assign off     = s_addr_q[1:0];
    assign ld_byte = h_i_dmem_rdata[8*off +: 8];
    assign ld_half = off[1] ? h_i_dmem_rdata[31:16] : h_i_dmem_rdata[15:0];

    always_comb begin
        ld_data = h_i_dmem_rdata;
        case (s_funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = h_i_dmem_rdata;
        endcase
    end

    always_comb begin
        st_wdata = s_wdata_q;
        st_be    = 4'b1111;
        if (s_store_q) begin
            case (s_funct3_q[1:0])
                2'b00: begin
                    st_wdata = {4{s_wdata_q[7:0]}};
                    st_be    = 4'b0001 << off;
                end
                2'b01: begin
                    st_wdata = {2{s_wdata_q[15:0]}};
                    st_be    = 4'b0011 << off;
                end
                default: begin
                    st_wdata = s_wdata_q;
                    st_be    = 4'b1111;
                end
            endcase
        end
    end

    // Request fields come from S, so they are stable for the whole ST_REQ wait.
    assign h_o_dmem_req   = (state_q == ST_REQ);
    assign h_o_dmem_we    = h_o_dmem_req && s_store_q;
    assign h_o_dmem_addr  = h_o_dmem_req ? {s_addr_q[31:2], 2'b00} : '0;
    assign h_o_dmem_wdata = h_o_dmem_req ? st_wdata : '0;
    assign h_o_dmem_be    = h_o_dmem_req ? st_be : 4'b0000;

    always_comb begin
        state_d      = state_q;
        s_valid_d    = s_valid_q;
        s_complete_d = s_complete_q;
        s_we_reg_d   = s_we_reg_q;
        s_rd_d       = s_rd_q;
        s_data_d     = s_data_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_funct3_d   = s_funct3_q;
        s_load_d     = s_load_q;
        s_store_d    = s_store_q;
        s_misal_d    = s_misal_q;

        if (state_q == ST_REQ) begin
            // An outstanding request is never abandoned; a flush only strips
            // the register write from the instruction.
            if (h_i_flush) s_we_reg_d = 1'b0;
            if (h_i_dmem_ack) begin
                s_complete_d = 1'b1;
                if (s_load_q) s_data_d = ld_data;
                state_d = ST_IDLE;
            end
        end else begin
            if (h_i_flush || retire) begin
                s_valid_d    = 1'b0;
                s_complete_d = 1'b0;
                s_misal_d    = 1'b0;
            end
            if (accept) begin
                s_valid_d  = 1'b1;
                s_rd_d     = h_i_addr_rd;
                s_data_d   = h_i_alu_result;
                s_addr_d   = h_i_alu_result;
                s_wdata_d  = h_i_rs2_data;
                s_funct3_d = h_i_funct3;
                s_load_d   = h_i_is_load;
                s_store_d  = h_i_is_store;
                s_misal_d  = in_misal;
                s_we_reg_d = h_i_we_reg && !in_misal;
                if (in_mem && !in_misal) begin
                    s_complete_d = 1'b0;
                    state_d      = ST_REQ;
                end else begin
                    s_complete_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            state_q      <= ST_IDLE;
            s_valid_q    <= 1'b0;
            s_complete_q <= 1'b0;
            s_we_reg_q   <= 1'b0;
            s_rd_q       <= '0;
            s_data_q     <= '0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_funct3_q   <= 3'b000;
            s_load_q     <= 1'b0;
            s_store_q    <= 1'b0;
            s_misal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_valid_q    <= s_valid_d;
            s_complete_q <= s_complete_d;
            s_we_reg_q   <= s_we_reg_d;
            s_rd_q       <= s_rd_d;
            s_data_q     <= s_data_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_funct3_q   <= s_funct3_d;
            s_load_q     <= s_load_d;
            s_store_q    <= s_store_d;
            s_misal_q    <= s_misal_d;
        end
    end

    // WB register: holds while writeback stalls, otherwise pulses once per retire.
    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            wb_ce_q     <= 1'b0;
            wb_we_reg_q <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else if (!h_i_stall) begin
            wb_ce_q <= wb_load;
            if (wb_load) begin
                wb_we_reg_q <= s_we_reg_q;
                wb_rd_q     <= s_rd_q;
                wb_data_q   <= s_data_q;
            end else begin
                wb_we_reg_q <= 1'b0;
            end
        end
    end

    assign h_o_fwd_ce      = s_valid_q;
    assign h_o_fwd_valid   = s_valid_q && s_complete_q;
    assign h_o_fwd_we_reg  = s_we_reg_q;
    assign h_o_fwd_addr_rd = s_rd_q;
    assign h_o_fwd_data_rd = s_data_q;
    assign h_o_misaligned  = s_valid_q && s_misal_q;

    assign h_o_wb_ce      = wb_ce_q;
    assign h_o_wb_we_reg  = wb_we_reg_q;
    assign h_o_wb_addr_rd = wb_rd_q;
    assign h_o_wb_data_rd = wb_data_q;

endmodule

// File: tb/tb_memoryaccess_stage.sv
// tb/tb_memoryaccess_stage.sv - directed self-checking bench for memoryaccess_stage
module tb_memoryaccess_stage;

    logic        h_clk = 1'b0;
    logic        h_rst;
    logic        h_i_ce, h_i_we_reg, h_i_is_load, h_i_is_store, h_i_stall, h_i_flush;
    logic [4:0]  h_i_addr_rd;
    logic [31:0] h_i_alu_result, h_i_rs2_data, h_i_dmem_rdata;
    logic [2:0]  h_i_funct3;
    logic        h_i_dmem_ack;
    logic        h_o_stall, h_o_fwd_ce, h_o_fwd_we_reg, h_o_fwd_valid, h_o_misaligned;
    logic [4:0]  h_o_fwd_addr_rd, h_o_wb_addr_rd;
    logic [31:0] h_o_fwd_data_rd, h_o_dmem_addr, h_o_dmem_wdata, h_o_wb_data_rd;
    logic        h_o_dmem_req, h_o_dmem_we, h_o_wb_ce, h_o_wb_we_reg;
    logic [3:0]  h_o_dmem_be;

    int checks = 0;
    int failures = 0;

    memoryaccess_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
        .h_clk(h_clk), .h_rst(h_rst),
        .h_i_ce(h_i_ce), .h_i_we_reg(h_i_we_reg), .h_i_addr_rd(h_i_addr_rd),
        .h_i_alu_result(h_i_alu_result), .h_i_rs2_data(h_i_rs2_data),
        .h_i_is_load(h_i_is_load), .h_i_is_store(h_i_is_store), .h_i_funct3(h_i_funct3),
        .h_i_stall(h_i_stall), .h_i_flush(h_i_flush), .h_o_stall(h_o_stall),
        .h_o_fwd_ce(h_o_fwd_ce), .h_o_fwd_we_reg(h_o_fwd_we_reg),
        .h_o_fwd_addr_rd(h_o_fwd_addr_rd), .h_o_fwd_data_rd(h_o_fwd_data_rd),
        .h_o_fwd_valid(h_o_fwd_valid), .h_o_misaligned(h_o_misaligned),
        .h_o_dmem_req(h_o_dmem_req), .h_o_dmem_we(h_o_dmem_we), .h_o_dmem_addr(h_o_dmem_addr),
        .h_o_dmem_wdata(h_o_dmem_wdata), .h_o_dmem_be(h_o_dmem_be),
        .h_i_dmem_ack(h_i_dmem_ack), .h_i_dmem_rdata(h_i_dmem_rdata),
        .h_o_wb_ce(h_o_wb_ce), .h_o_wb_we_reg(h_o_wb_we_reg),
        .h_o_wb_addr_rd(h_o_wb_addr_rd), .h_o_wb_data_rd(h_o_wb_data_rd)
    );

    always #5 h_clk = ~h_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge h_clk);
        #1;
    endtask

    task automatic idle_inputs();
        h_i_ce = 0; h_i_we_reg = 0; h_i_addr_rd = 0; h_i_alu_result = 0; h_i_rs2_data = 0;
        h_i_is_load = 0; h_i_is_store = 0; h_i_funct3 = 0; h_i_stall = 0; h_i_flush = 0;
        h_i_dmem_ack = 0; h_i_dmem_rdata = 0;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic we, input logic [4:0] rd);
        h_i_ce = 1; h_i_is_load = ld; h_i_is_store = st; h_i_funct3 = f3;
        h_i_alu_result = addr; h_i_rs2_data = rs2; h_i_we_reg = we; h_i_addr_rd = rd;
        tick();
        h_i_ce = 0; h_i_is_load = 0; h_i_is_store = 0;
        #1;
    endtask

    task automatic load_same_cycle(input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] rdata, input logic [31:0] exp, input string tag);
        issue(1, 0, f3, addr, 0, 1, 9);
        chk({tag, "_req"}, h_o_dmem_req, 1);
        h_i_dmem_ack = 1; h_i_dmem_rdata = rdata;
        tick();
        h_i_dmem_ack = 0;
        #1;
        chk({tag, "_data"}, h_o_fwd_data_rd, exp);
        tick();
        chk({tag, "_wb"}, h_o_wb_data_rd, exp);
        tick();
    endtask

    initial begin
        idle_inputs();
        h_rst = 0;
        #12;
        chk("rst_stall", h_o_stall, 0);
        chk("rst_fwd_ce", h_o_fwd_ce, 0);
        chk("rst_req", h_o_dmem_req, 0);
        chk("rst_wb_ce", h_o_wb_ce, 0);
        chk("rst_be", h_o_dmem_be, 0);
        h_rst = 1;
        tick();

        // ADD to rd 5
        issue(0, 0, 3'b000, 32'h0000_1234, 0, 1, 5);
        chk("add_fwd_ce", h_o_fwd_ce, 1);
        chk("add_fwd_valid", h_o_fwd_valid, 1);
        chk("add_fwd_data", h_o_fwd_data_rd, 32'h1234);
        chk("add_stall", h_o_stall, 0);
        tick();
        chk("add_wb_ce", h_o_wb_ce, 1);
        chk("add_wb_addr", h_o_wb_addr_rd, 5);
        chk("add_wb_data", h_o_wb_data_rd, 32'h1234);
        chk("add_wb_we", h_o_wb_we_reg, 1);
        chk("add_empty", h_o_fwd_ce, 0);
        tick();
        chk("add_wb_pulse", h_o_wb_ce, 0);

        // LW 0x100, ack after 3 waiting cycles
        issue(1, 0, 3'b010, 32'h100, 0, 1, 6);
        for (int i = 0; i < 3; i++) begin
            chk("lw_req", h_o_dmem_req, 1);
            chk("lw_addr", h_o_dmem_addr, 32'h100);
            chk("lw_we", h_o_dmem_we, 0);
            chk("lw_be", h_o_dmem_be, 4'b1111);
            chk("lw_stall", h_o_stall, 1);
            chk("lw_fwd_valid", h_o_fwd_valid, 0);
            tick();
        end
        h_i_dmem_ack = 1; h_i_dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("lw_req_ack", h_o_dmem_req, 1);
        tick();
        h_i_dmem_ack = 0;
        #1;
        chk("lw_req_drop", h_o_dmem_req, 0);
        chk("lw_fwd_valid1", h_o_fwd_valid, 1);
        chk("lw_fwd_data", h_o_fwd_data_rd, 32'hDEAD_BEEF);
        chk("lw_stall0", h_o_stall, 0);
        tick();
        chk("lw_wb_ce", h_o_wb_ce, 1);
        chk("lw_wb_data", h_o_wb_data_rd, 32'hDEAD_BEEF);
        chk("lw_wb_addr", h_o_wb_addr_rd, 6);
        tick();

        // Byte / half loads
        load_same_cycle(3'b000, 32'h203, 32'h80FF_0000, 32'hFFFF_FF80, "lb");
        load_same_cycle(3'b100, 32'h203, 32'h80FF_0000, 32'h0000_0080, "lbu");
        load_same_cycle(3'b001, 32'h202, 32'h80FF_0000, 32'hFFFF_80FF, "lh");
        load_same_cycle(3'b101, 32'h200, 32'h1234_8001, 32'h0000_8001, "lhu");

        // SH 0x102, ack in first request cycle
        issue(0, 1, 3'b001, 32'h102, 32'hAAAA_1234, 0, 0);
        chk("sh_req", h_o_dmem_req, 1);
        chk("sh_we", h_o_dmem_we, 1);
        chk("sh_addr", h_o_dmem_addr, 32'h100);
        chk("sh_wdata", h_o_dmem_wdata, 32'h1234_1234);
        chk("sh_be", h_o_dmem_be, 4'b1100);
        h_i_dmem_ack = 1;
        tick();
        h_i_dmem_ack = 0;
        #1;
        chk("sh_complete", h_o_fwd_valid, 1);
        chk("sh_req0", h_o_dmem_req, 0);
        tick();
        chk("sh_wb_ce", h_o_wb_ce, 1);
        chk("sh_wb_we", h_o_wb_we_reg, 0);
        tick();

        // SB offset 1
        issue(0, 1, 3'b000, 32'h301, 32'h0000_00A5, 0, 0);
        chk("sb_wdata", h_o_dmem_wdata, 32'hA5A5_A5A5);
        chk("sb_be", h_o_dmem_be, 4'b0010);
        h_i_dmem_ack = 1;
        tick();
        h_i_dmem_ack = 0;
        tick();
        tick();

        // Misaligned LW 0x102
        issue(1, 0, 3'b010, 32'h102, 0, 1, 4);
        chk("mis_req", h_o_dmem_req, 0);
        chk("mis_flag", h_o_misaligned, 1);
        chk("mis_fwd_valid", h_o_fwd_valid, 1);
        chk("mis_fwd_we", h_o_fwd_we_reg, 0);
        tick();
        chk("mis_wb_ce", h_o_wb_ce, 1);
        chk("mis_wb_we", h_o_wb_we_reg, 0);
        chk("mis_flag0", h_o_misaligned, 0);
        tick();

        // Flush during a 2-cycle load wait
        issue(1, 0, 3'b010, 32'h100, 0, 1, 7);
        h_i_flush = 1;
        #1;
        chk("fl_req", h_o_dmem_req, 1);
        tick();
        h_i_flush = 0;
        #1;
        chk("fl_req_held", h_o_dmem_req, 1);
        chk("fl_fwd_ce", h_o_fwd_ce, 1);
        h_i_dmem_ack = 1; h_i_dmem_rdata = 32'h0000_0011;
        tick();
        h_i_dmem_ack = 0;
        #1;
        chk("fl_fwd_valid", h_o_fwd_valid, 1);
        chk("fl_fwd_we", h_o_fwd_we_reg, 0);
        tick();
        chk("fl_wb_ce", h_o_wb_ce, 1);
        chk("fl_wb_we", h_o_wb_we_reg, 0);
        chk("fl_wb_data", h_o_wb_data_rd, 32'h11);
        tick();

        // Writeback stall for 4 cycles with a complete ADD in S
        issue(0, 0, 3'b000, 32'h55, 0, 1, 3);
        h_i_stall = 1;
        h_i_ce = 1; h_i_alu_result = 32'h99; h_i_addr_rd = 8;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("st_stall", h_o_stall, 1);
            chk("st_fwd_data", h_o_fwd_data_rd, 32'h55);
            chk("st_fwd_valid", h_o_fwd_valid, 1);
            chk("st_wb_ce", h_o_wb_ce, 0);
            tick();
        end
        h_i_stall = 0; h_i_ce = 0;
        tick();
        chk("st_wb_ce1", h_o_wb_ce, 1);
        chk("st_wb_data", h_o_wb_data_rd, 32'h55);
        chk("st_wb_addr", h_o_wb_addr_rd, 3);
        chk("st_new_not_taken", h_o_fwd_ce, 0);
        tick();

        // Reset while a request is outstanding
        issue(1, 0, 3'b010, 32'h400, 0, 1, 2);
        chk("rr_req", h_o_dmem_req, 1);
        h_rst = 0;
        #1;
        chk("rr_req0", h_o_dmem_req, 0);
        chk("rr_fwd_ce", h_o_fwd_ce, 0);
        chk("rr_stall", h_o_stall, 0);
        chk("rr_addr", h_o_dmem_addr, 0);
        h_i_dmem_ack = 1;
        tick();
        h_i_dmem_ack = 0;
        h_rst = 1;
        tick();
        chk("rr_after_req", h_o_dmem_req, 0);
        chk("rr_after_wb", h_o_wb_ce, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
